// File: rtl/lsu_subword_if.sv
// rtl/lsu_subword_if.sv - request/memory/response bundle for the sub-word load/store unit
interface lsu_subword_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              is_store_i;
    logic [1:0]        size_i;
    logic              unsigned_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [ADDR_W-1:0] offset_i;
    logic [31:0]       store_data_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_wstrb_o;
    logic              mem_valid_o;
    logic              mem_ready_i;
    logic [31:0]       mem_rdata_i;
    logic              resp_valid_o;
    logic [31:0]       load_data_o;
    logic              err_misaligned_o;
    logic              err_timeout_o;

    modport slave (
        input  req_valid_i, is_store_i, size_i, unsigned_i, base_addr_i, offset_i,
               store_data_i, mem_ready_i, mem_rdata_i,
        output req_ready_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_valid_o,
               resp_valid_o, load_data_o, err_misaligned_o, err_timeout_o
    );

    modport master (
        output req_valid_i, is_store_i, size_i, unsigned_i, base_addr_i, offset_i,
               store_data_i, mem_ready_i, mem_rdata_i,
        input  req_ready_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_valid_o,
               resp_valid_o, load_data_o, err_misaligned_o, err_timeout_o
    );
endinterface

// File: rtl/lsu_subword.sv
// rtl/lsu_subword.sv - byte/half/word load-store unit with alignment trap and access timeout
module lsu_subword #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ALIGN_CHECK    = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    lsu_subword_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic              is_store_q;
    logic [1:0]        lane_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
    logic              mem_valid_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [31:0]       load_data_q;
    logic              err_mis_q;
    logic              err_to_q;

    logic [ADDR_W-1:0] ea_d;
    logic              misaligned_d;
    logic              trap_d;
    logic [1:0]        lane_d;
    logic [3:0]        wstrb_d;
    logic [31:0]       wdata_d;
    logic [31:0]       shifted_d;
    logic [31:0]       load_d;

    // Request decode: misaligned half/word accesses that are not trapped fall back to lane 0.
    always_comb begin
        ea_d         = bus.base_addr_i + bus.offset_i;
        misaligned_d = 1'b0;
        wstrb_d      = 4'b0000;
        wdata_d      = bus.store_data_i;
        case (bus.size_i)
            2'b01:   misaligned_d = ea_d[0];
            2'b10:   misaligned_d = (ea_d[1:0] != 2'b00);
            2'b11:   misaligned_d = 1'b1;
            default: misaligned_d = 1'b0;
        endcase
        trap_d = (bus.size_i == 2'b11) || ((ALIGN_CHECK != 0) && misaligned_d);
        lane_d = misaligned_d ? 2'b00 : ea_d[1:0];
        case (bus.size_i)
            2'b00: begin
                wstrb_d = 4'b0001 << lane_d;
                wdata_d = {4{bus.store_data_i[7:0]}};
            end
            2'b01: begin
                wstrb_d = 4'b0011 << lane_d;
                wdata_d = {2{bus.store_data_i[15:0]}};
            end
            default: begin
                wstrb_d = 4'b1111;
                wdata_d = bus.store_data_i;
            end
        endcase
        if (!bus.is_store_i) begin
            wstrb_d = 4'b0000;
        end
    end

    always_comb begin
        shifted_d = bus.mem_rdata_i >> {lane_q, 3'b000};
        case (size_q)
            2'b00:   load_d = unsigned_q ? {24'b0, shifted_d[7:0]}
                                         : {{24{shifted_d[7]}}, shifted_d[7:0]};
            2'b01:   load_d = unsigned_q ? {16'b0, shifted_d[15:0]}
                                         : {{16{shifted_d[15]}}, shifted_d[15:0]};
            default: load_d = bus.mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            is_store_q   <= 1'b0;
            lane_q       <= 2'b00;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= 4'b0000;
            mem_valid_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            load_data_q  <= '0;
            err_mis_q    <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        size_q      <= bus.size_i;
                        unsigned_q  <= bus.unsigned_i;
                        is_store_q  <= bus.is_store_i;
                        lane_q      <= lane_d;
                        mem_addr_q  <= {ea_d[ADDR_W-1:2], 2'b00};
                        mem_wdata_q <= wdata_d;
                        mem_wstrb_q <= wstrb_d;
                        req_ready_q <= 1'b0;
                        if (trap_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            err_mis_q    <= 1'b1;
                        end else begin
                            state_q     <= ACCESS;
                            mem_valid_q <= 1'b1;
                            cnt_q       <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // A ready arriving on the last allowed cycle wins over the timeout.
                    if (bus.mem_ready_i) begin
                        state_q      <= RESP;
                        mem_valid_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        if (!is_store_q) begin
                            load_data_q <= load_d;
                        end
                    end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
                        state_q      <= RESP;
                        mem_valid_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        err_to_q     <= 1'b1;
                        if (!is_store_q) begin
                            load_data_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    err_mis_q    <= 1'b0;
                    err_to_q     <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q      <= IDLE;
                    mem_valid_q  <= 1'b0;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready_o      = req_ready_q;
    assign bus.mem_addr_o       = mem_addr_q;
    assign bus.mem_wdata_o      = mem_wdata_q;
    assign bus.mem_wstrb_o      = mem_wstrb_q;
    assign bus.mem_valid_o      = mem_valid_q;
    assign bus.resp_valid_o     = resp_valid_q;
    assign bus.load_data_o      = load_data_q;
    assign bus.err_misaligned_o = err_mis_q;
    assign bus.err_timeout_o    = err_to_q;
endmodule

// File: tb/tb_lsu_subword.sv
// tb/tb_lsu_subword.sv - self-checking bench for lsu_subword against a behavioural access model
module tb_lsu_subword;
    localparam int TO = 4;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    logic [31:0] exp_ld;

    lsu_subword_if #(.ADDR_W(32)) bus ();

    lsu_subword #(
        .ADDR_W(32),
        .TIMEOUT_CYCLES(TO),
        .ALIGN_CHECK(1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Model: one request; delay = number of not-ready ACCESS cycles before ready (large = never).
    task automatic run(input bit st, input logic [1:0] sz, input bit un,
                       input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] sdata, input logic [31:0] rdata, input int delay);
        logic [31:0] ea, e_addr, e_wdata, e_load, v;
        logic [3:0]  e_strb;
        bit          mis, to;
        int          nbytes, e_acc, cycle, acc;
        bit          seen;
        ea     = base + off;
        mis    = (sz == 2'd3) || (sz == 2'd1 && ea % 2 != 0) || (sz == 2'd2 && ea % 4 != 0);
        to     = !mis && delay >= TO;
        e_acc  = mis ? 0 : (to ? TO : delay + 1);
        e_addr = ea - (ea % 4);
        nbytes = 1 << sz;
        e_strb = st ? 4'(((1 << nbytes) - 1) << (ea % 4)) : 4'b0000;
        if (sz == 2'd0)      e_wdata = sdata[7:0] * 32'h01010101;
        else if (sz == 2'd1) e_wdata = sdata[15:0] * 32'h00010001;
        else                 e_wdata = sdata;
        v = rdata >> (8 * (ea % 4));
        if (sz == 2'd0) begin
            e_load = v % 256;
            if (!un && e_load >= 128) e_load = e_load + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            e_load = v % 65536;
            if (!un && e_load >= 32768) e_load = e_load + 32'hFFFF0000;
        end else begin
            e_load = rdata;
        end
        if (!st && !mis) exp_ld = to ? 32'h0 : e_load;

        @(negedge clk);
        chk("ready_in_idle", bus.req_ready_o, 1);
        chk("no_resp_in_idle", bus.resp_valid_o, 0);
        bus.req_valid_i  = 1'b1;
        bus.is_store_i   = st;
        bus.size_i       = sz;
        bus.unsigned_i   = un;
        bus.base_addr_i  = base;
        bus.offset_i     = off;
        bus.store_data_i = sdata;
        bus.mem_rdata_i  = rdata;
        bus.mem_ready_i  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        cycle = 0;
        acc   = 0;
        seen  = 0;
        while (!seen && cycle < 30) begin
            @(negedge clk);
            cycle++;
            if (bus.mem_valid_o) begin
                acc++;
                if (acc == 1) begin
                    chk("mem_addr", bus.mem_addr_o, e_addr);
                    chk("mem_wstrb", 32'(bus.mem_wstrb_o), 32'(e_strb));
                    if (st) chk("mem_wdata", bus.mem_wdata_o, e_wdata);
                end
                bus.mem_ready_i = (acc - 1 == delay);
            end else begin
                bus.mem_ready_i = 1'($urandom_range(0, 1));
            end
            if (bus.resp_valid_o) begin
                seen = 1;
                chk("latency", cycle, e_acc + 1);
                chk("access_cycles", acc, e_acc);
                chk("err_misaligned", bus.err_misaligned_o, 32'(mis));
                chk("err_timeout", bus.err_timeout_o, 32'(to));
                chk("load_data", bus.load_data_o, exp_ld);
                chk("ready_in_resp", bus.req_ready_o, 0);
                chk("mem_valid_in_resp", bus.mem_valid_o, 0);
            end
        end
        if (!seen) chk("resp_wait_expired", 0, 1);
        bus.mem_ready_i = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_ld   = 32'h0;
        rst_n    = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.is_store_i   = 1'b0;
        bus.size_i       = 2'b00;
        bus.unsigned_i   = 1'b0;
        bus.base_addr_i  = '0;
        bus.offset_i     = '0;
        bus.store_data_i = '0;
        bus.mem_ready_i  = 1'b0;
        bus.mem_rdata_i  = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready_o, 1);
        chk("rst_mem_valid", bus.mem_valid_o, 0);
        chk("rst_resp_valid", bus.resp_valid_o, 0);
        chk("rst_load_data", bus.load_data_o, 0);
        chk("rst_wstrb", 32'(bus.mem_wstrb_o), 0);
        chk("rst_addr", bus.mem_addr_o, 0);
        chk("rst_errs", {bus.err_misaligned_o, bus.err_timeout_o}, 0);
        rst_n = 1'b1;

        run(0, 2'd2, 0, 32'h100, 32'h4, 32'h0, 32'hDEADBEEF, 0);
        chk("lw_literal", bus.load_data_o, 32'hDEADBEEF);
        run(0, 2'd0, 0, 32'h100, 32'h3, 32'h0, 32'h80FF7F01, 0);
        chk("lb_literal", bus.load_data_o, 32'hFFFFFF80);
        run(0, 2'd0, 1, 32'h100, 32'h3, 32'h0, 32'h80FF7F01, 0);
        chk("lbu_literal", bus.load_data_o, 32'h00000080);
        run(1, 2'd1, 0, 32'h200, 32'h2, 32'h1234ABCD, 32'h0, 0);
        run(0, 2'd2, 0, 32'h100, 32'h1, 32'h0, 32'h11111111, 0);
        run(0, 2'd3, 0, 32'h100, 32'h0, 32'h0, 32'h22222222, 0);
        chk("mis_keeps_load", bus.load_data_o, 32'h00000080);
        run(0, 2'd2, 0, 32'h300, 32'h0, 32'h0, 32'h5555AAAA, 99);
        chk("timeout_literal", bus.load_data_o, 32'h0);
        run(0, 2'd2, 0, 32'h300, 32'h0, 32'h0, 32'h5555AAAA, TO - 1);
        run(1, 2'd2, 0, 32'h400, 32'hFFFFFFFC, 32'hCAFEF00D, 32'h0, 99);
        run(0, 2'd1, 0, 32'hFFFFFFFE, 32'h4, 32'h0, 32'h8001_7FFF, 2);

        // Reset in the second ACCESS cycle aborts the access without a response.
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.is_store_i  = 1'b0;
        bus.size_i      = 2'd2;
        bus.base_addr_i = 32'h500;
        bus.offset_i    = 32'h0;
        bus.mem_ready_i = 1'b0;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("abort_access1", bus.mem_valid_o, 1);
        @(negedge clk);
        chk("abort_access2", bus.mem_valid_o, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_mem_valid", bus.mem_valid_o, 0);
        chk("abort_resp", bus.resp_valid_o, 0);
        chk("abort_ready", bus.req_ready_o, 1);
        exp_ld = 32'h0;
        chk("abort_load_data", bus.load_data_o, exp_ld);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_resp", bus.resp_valid_o, 0);
        end

        for (int i = 0; i < 60; i++) begin
            run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, 32'($urandom_range(0, 15)), $urandom, $urandom,
                int'($urandom_range(0, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
